// File: rtl/alu_spi_responder_if.sv
// Serial link bundle between the processor (master) and the ALU responder (slave).
// The link clock is the shared system clock, so it is not carried here.
interface Spi;
    logic nss;
    logic mosi;
    logic miso;

    modport SlaveSpi (
        input  nss,
        input  mosi,
        output miso
    );

    modport MasterSpi (
        output nss,
        output mosi,
        input  miso
    );
endinterface

// File: rtl/alu_spi_responder.sv
// ALU end of the processor-to-ALU serial link: receives {rs2, rs1, op} LSB-first,
// computes the result and returns a start bit followed by the result LSB-first.
module alu_spi_responder #(
    parameter int DATA_WIDTH = 8,
    parameter int OP_WIDTH   = 3
) (
    input  logic  i_clock,
    input  logic  i_reset,
    Spi.SlaveSpi  spi,
    output logic  o_busy,
    output logic  o_done
);
    localparam int PACKET_BITS = 2 * DATA_WIDTH + OP_WIDTH;
    localparam int COUNT_W     = $clog2(PACKET_BITS);
    localparam int SHAMT_W     = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        EXEC,
        RESP_START,
        RESP
    } state_e;

    state_e                  stateQ;
    logic [COUNT_W-1:0]      countQ;
    logic [PACKET_BITS-1:0]  packetQ;
    logic [DATA_WIDTH-1:0]   resultQ;
    logic [DATA_WIDTH-1:0]   resultD;
    logic                    misoQ;
    logic                    busyQ;
    logic                    doneQ;

    logic [OP_WIDTH-1:0]     opcode;
    logic [DATA_WIDTH-1:0]   rs1;
    logic [DATA_WIDTH-1:0]   rs2;

    assign opcode = packetQ[OP_WIDTH-1:0];
    assign rs1    = packetQ[OP_WIDTH +: DATA_WIDTH];
    assign rs2    = packetQ[OP_WIDTH+DATA_WIDTH +: DATA_WIDTH];

    // Shift ops use only the low log2(DATA_WIDTH) bits of rs2 as the amount
    always_comb begin
        resultD = '0;
        case (int'(opcode))
            0: resultD = rs1 + rs2;
            1: resultD = rs1 - rs2;
            2: resultD = rs1 & rs2;
            3: resultD = rs1 | rs2;
            4: resultD = rs1 ^ rs2;
            5: resultD = rs1 << rs2[SHAMT_W-1:0];
            6: resultD = rs1 >> rs2[SHAMT_W-1:0];
            7: resultD = DATA_WIDTH'($signed(rs1) < $signed(rs2));
            default: resultD = '0;
        endcase
    end

    // Outputs are registered alongside the state; the result register is
    // shifted right during the response so bit 0 always holds the next bit out.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            stateQ  <= IDLE;
            countQ  <= '0;
            packetQ <= '0;
            resultQ <= '0;
            misoQ   <= 1'b0;
            busyQ   <= 1'b0;
            doneQ   <= 1'b0;
        end else begin
            doneQ <= 1'b0;
            if (stateQ != IDLE && spi.nss) begin
                stateQ <= IDLE;
                countQ <= '0;
                misoQ  <= 1'b0;
                busyQ  <= 1'b0;
            end else begin
                case (stateQ)
                    IDLE: begin
                        misoQ <= 1'b0;
                        if (!spi.nss && spi.mosi) begin
                            stateQ <= RECV;
                            countQ <= '0;
                            busyQ  <= 1'b1;
                        end
                    end
                    RECV: begin
                        packetQ <= {spi.mosi, packetQ[PACKET_BITS-1:1]};
                        if (countQ == COUNT_W'(PACKET_BITS - 1)) begin
                            stateQ <= EXEC;
                            countQ <= '0;
                        end else begin
                            countQ <= countQ + 1'b1;
                        end
                    end
                    EXEC: begin
                        resultQ <= resultD;
                        stateQ  <= RESP_START;
                        misoQ   <= 1'b1;
                    end
                    RESP_START: begin
                        stateQ  <= RESP;
                        countQ  <= '0;
                        misoQ   <= resultQ[0];
                        resultQ <= resultQ >> 1;
                    end
                    RESP: begin
                        if (countQ == COUNT_W'(DATA_WIDTH - 1)) begin
                            stateQ <= IDLE;
                            countQ <= '0;
                            misoQ  <= 1'b0;
                            busyQ  <= 1'b0;
                            doneQ  <= 1'b1;
                        end else begin
                            countQ  <= countQ + 1'b1;
                            misoQ   <= resultQ[0];
                            resultQ <= resultQ >> 1;
                        end
                    end
                    default: begin
                        stateQ <= IDLE;
                        countQ <= '0;
                        misoQ  <= 1'b0;
                        busyQ  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign spi.miso = misoQ;
    assign o_busy   = busyQ;
    assign o_done   = doneQ;
endmodule
